// File: rtl/riscv_gdb_pkg.sv
// Shared GDB RSP definitions used by the stub transmitter and receiver.
package riscv_gdb_pkg;

    localparam logic [7:0] CH_SOF  = 8'h24;
    localparam logic [7:0] CH_EOF  = 8'h23;
    localparam logic [7:0] CH_ESC  = 8'h7d;
    localparam logic [7:0] CH_RLE  = 8'h2a;
    localparam logic [7:0] CH_ACK  = 8'h2b;
    localparam logic [7:0] CH_NAK  = 8'h2d;
    localparam logic [7:0] ESC_XOR = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_DAT,
        ST_ESC,
        ST_EOF,
        ST_CSH,
        ST_CSL,
        ST_WAIT_ACK
    } rsp_tx_state_t;

    function automatic logic [7:0] hex2asc(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    function automatic logic needs_esc(input logic [7:0] b);
        return (b == CH_SOF) || (b == CH_EOF) || (b == CH_ESC) || (b == CH_RLE);
    endfunction

endpackage

// File: rtl/riscv_gdb_rsp_buf.sv
// Retransmit store for one RSP payload: written while the packet goes out live,
// replayed from the start on a resend. One shared pointer serves both directions.
module riscv_gdb_rsp_buf #(
    parameter int BUF_SIZ = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_dat,
    input  logic       rd_start,
    input  logic       rd_en,
    output logic [7:0] rd_dat,
    output logic       rd_end,
    output logic       ovf
);
    localparam int AW = (BUF_SIZ > 1) ? $clog2(BUF_SIZ) : 1;
    localparam int PW = $clog2(BUF_SIZ + 1);

    logic [7:0]    mem [BUF_SIZ];
    logic [PW-1:0] ptr;
    logic [PW-1:0] len;
    logic          room;

    assign room   = ptr < PW'(BUF_SIZ);
    assign rd_dat = mem[ptr[AW-1:0]];
    assign rd_end = ptr == len;

    always_ff @(posedge clk) begin
        if (wr_en && room) mem[ptr[AW-1:0]] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            ptr <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (wr_en) begin
            if (room) begin
                ptr <= ptr + 1'b1;
                len <= ptr + 1'b1;
            end else begin
                ovf <= 1'b1;
            end
        end else if (rd_start) begin
            ptr <= '0;
        end else if (rd_en) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_gdb_rsp_tx.sv
// GDB RSP packet transmitter: frames "$payload#cc", escapes, waits for '+'/'-'.
// RISCV_GDB_RSP_RETX_EN adds the replay buffer and retry counter for resends.
//
// state    | meaning
// IDLE     | no packet; first pld_vld loads '$'
// SOF      | resend: load '$' and replay from the buffer
// DAT      | pass payload bytes (live or replayed)
// ESC      | emit the xor'd byte after a '}'
// EOF      | load '#'
// CSH/CSL  | load checksum high/low hex digit
// WAIT_ACK | low digit draining, then wait for host ack, NAK or timeout
module riscv_gdb_rsp_tx
    import riscv_gdb_pkg::*;
#(
    parameter int BUF_SIZ   = 256,
    parameter int ACK_TMO   = 4096,
    parameter int RETRY_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pld_vld,
    output logic       pld_rdy,
    input  logic [7:0] pld_dat,
    input  logic       pld_lst,
    input  logic       pld_emp,
    output logic       tx_vld,
    input  logic       tx_rdy,
    output logic [7:0] tx_dat,
    input  logic       ack_vld,
    input  logic [7:0] ack_dat,
    input  logic       noack,
    output logic       busy,
    output logic       err
);
    localparam int TW = (ACK_TMO > 1) ? $clog2(ACK_TMO + 1) : 1;

    rsp_tx_state_t state, state_nxt;
    logic          slot_free, ld_en, cs_add, cs_clr, done, err_set;
    logic          tmo, nak, can_retry, replay, last_in;
    logic          esc_lst, esc_lst_nxt, buf_rd_end;
    logic [7:0]    ld_dat, cur_dat, cs, esc_dat, esc_nxt, buf_rd_dat;
    logic [TW-1:0] timer;

    assign slot_free = ~tx_vld | tx_rdy;
    assign cur_dat   = replay ? buf_rd_dat : pld_dat;
    assign last_in   = pld_lst & ~replay;
    assign cs_clr    = ld_en & ((state == ST_IDLE) | (state == ST_SOF));
    assign tmo       = (ACK_TMO != 0) && (timer == '0);
    assign nak       = (state == ST_WAIT_ACK) & ~tx_vld & ((ack_vld & (ack_dat == CH_NAK)) | tmo);

    always_comb begin
        state_nxt   = state;
        ld_en       = 1'b0;
        ld_dat      = tx_dat;
        cs_add      = 1'b0;
        pld_rdy     = 1'b0;
        esc_nxt     = esc_dat;
        esc_lst_nxt = esc_lst;
        done        = 1'b0;
        err_set     = 1'b0;
        case (state)
            ST_IDLE, ST_SOF: begin
                if (slot_free && (pld_vld || state == ST_SOF)) begin
                    ld_en     = 1'b1;
                    ld_dat    = CH_SOF;
                    state_nxt = ST_DAT;
                end
            end
            ST_DAT: begin
                pld_rdy = slot_free & ~replay;
                if (slot_free && (replay ? buf_rd_end : (pld_vld && pld_emp))) begin
                    state_nxt = ST_EOF;
                end else if (slot_free && (replay || pld_vld)) begin
                    ld_en  = 1'b1;
                    cs_add = 1'b1;
                    if (needs_esc(cur_dat)) begin
                        ld_dat      = CH_ESC;
                        esc_nxt     = cur_dat ^ ESC_XOR;
                        esc_lst_nxt = last_in;
                        state_nxt   = ST_ESC;
                    end else begin
                        ld_dat = cur_dat;
                        if (last_in) state_nxt = ST_EOF;
                    end
                end
            end
            ST_ESC: begin
                if (slot_free) begin
                    ld_en     = 1'b1;
                    cs_add    = 1'b1;
                    ld_dat    = esc_dat;
                    state_nxt = esc_lst ? ST_EOF : ST_DAT;
                end
            end
            ST_EOF: begin
                if (slot_free) begin
                    ld_en     = 1'b1;
                    ld_dat    = CH_EOF;
                    state_nxt = ST_CSH;
                end
            end
            ST_CSH: begin
                if (slot_free) begin
                    ld_en     = 1'b1;
                    ld_dat    = hex2asc(cs[7:4]);
                    state_nxt = ST_CSL;
                end
            end
            ST_CSL: begin
                if (slot_free) begin
                    ld_en     = 1'b1;
                    ld_dat    = hex2asc(cs[3:0]);
                    state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // noack is sampled as the last checksum digit leaves
                if (tx_vld) begin
                    if (tx_rdy && noack) begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (ack_vld && ack_dat == CH_ACK) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (nak) begin
                    if (can_retry) begin
                        state_nxt = ST_SOF;
                    end else begin
                        done      = 1'b1;
                        err_set   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_vld  <= 1'b0;
            tx_dat  <= 8'h00;
            cs      <= 8'h00;
            busy    <= 1'b0;
            err     <= 1'b0;
            esc_dat <= 8'h00;
            esc_lst <= 1'b0;
            timer   <= TW'(ACK_TMO);
        end else begin
            err     <= err_set;
            esc_dat <= esc_nxt;
            esc_lst <= esc_lst_nxt;
            if (ld_en) begin
                tx_vld <= 1'b1;
                tx_dat <= ld_dat;
            end else if (tx_rdy) begin
                tx_vld <= 1'b0;
            end
            if (cs_clr)      cs <= 8'h00;
            else if (cs_add) cs <= cs + ld_dat;
            if (ld_en && state == ST_IDLE) busy <= 1'b1;
            else if (done)                 busy <= 1'b0;
            if (state != ST_WAIT_ACK || tx_vld) timer <= TW'(ACK_TMO);
            else if (timer != '0)               timer <= timer - 1'b1;
        end
    end

`ifdef RISCV_GDB_RSP_RETX_EN
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    logic [RW-1:0] retry;
    logic          buf_ovf;

    riscv_gdb_rsp_buf #(
        .BUF_SIZ (BUF_SIZ)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (ld_en && state == ST_IDLE),
        .wr_en    (state == ST_DAT && !replay && pld_vld && pld_rdy && !pld_emp),
        .wr_dat   (pld_dat),
        .rd_start (ld_en && state == ST_SOF),
        .rd_en    (state == ST_DAT && replay && slot_free && !buf_rd_end),
        .rd_dat   (buf_rd_dat),
        .rd_end   (buf_rd_end),
        .ovf      (buf_ovf)
    );

    // a truncated buffer cannot reproduce the packet, so never resend it
    assign can_retry = ~buf_ovf & (retry != RW'(RETRY_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry  <= '0;
            replay <= 1'b0;
        end else if (ld_en && state == ST_IDLE) begin
            retry  <= '0;
            replay <= 1'b0;
        end else begin
            if (ld_en && state == ST_SOF) replay <= 1'b1;
            if (nak && can_retry)         retry  <= retry + 1'b1;
        end
    end
`else
    assign buf_rd_dat = 8'h00;
    assign buf_rd_end = 1'b1;
    assign replay     = 1'b0;
    assign can_retry  = 1'b0;
`endif

endmodule
